apb_i2s: RTL and testbench

APB_I2S -- requirements
Module: apb_i2s

---
 rtl/apb_i2s_if.sv | 13 +
 rtl/apb_i2s.sv | 115 +++++++++++
 tb/tb_apb_i2s.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/apb_i2s_if.sv
// apb_i2s_if: APB slave bus bundle for the I2S transmitter
interface apb_i2s_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
    modport slave (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_i2s.sv
// apb_i2s: APB-programmed I2S (Philips) transmitter with per-channel TX FIFOs
module apb_i2s #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCK_DIV    = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    apb_i2s_if.slave  apb,
    output logic      i2s_sck,
    output logic      i2s_ws,
    output logic      i2s_sd
);
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = $clog2(SCK_DIV);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state, state_nx;
    logic [31:0]   mem [2][FIFO_DEPTH];
    logic [AW-1:0] wp [2];
    logic [AW-1:0] rp [2];
    logic [CW-1:0] cnt [2];
    logic [63:0]   sh;
    logic [5:0]    bitc;
    logic [DW-1:0] div;
    logic          en, stop_req;
    logic          acc, wr, rd, pop, ready, last;
    logic [1:0]    push, full, empty, a;
    logic          unused_ok;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign a         = apb.paddr[3:2];
    assign acc       = apb.psel & apb.penable;
    assign wr        = acc & apb.pwrite;
    assign rd        = acc & ~apb.pwrite;
    assign unused_ok = ^{apb.paddr[31:4], apb.paddr[1:0]};
    // channel 0 is left (TXL), channel 1 is right (TXR)
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c]  = cnt[c] == CW'(FIFO_DEPTH);
            empty[c] = cnt[c] == '0;
        end
        push[0] = wr & (a == 2'd3) & ~full[0];
        push[1] = wr & (a == 2'd2) & ~full[1];
        ready   = ~empty[0] & ~empty[1];
        last    = (bitc == 6'd63) & (div == DW'(SCK_DIV - 1));
    end
    assign apb.pready  = 1'b1;
    assign apb.pslverr = wr & ~i_rst & (((a == 2'd3) & full[0]) | ((a == 2'd2) & full[1]));
    assign apb.prdata  = ~(rd & ~i_rst) ? 32'd0 :
                         a == 2'd0 ? {31'd0, en} :
                         a == 2'd1 ? {28'd0, empty[1], full[1], empty[0], full[0]} : 32'd0;
    always_ff @(posedge i_clk)
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE)       state_nx = en & ready ? LOAD : IDLE;
        else if (state == LOAD)  state_nx = SHIFT;
        else if (last)           state_nx = ~stop_req & ready ? LOAD : IDLE;
    end
    // LOAD doubles as the low half of bit 0's first sck cycle, so frames abut without a gap
    always_comb begin
        pop     = state == LOAD;
        i2s_sck = (state == SHIFT) & (div >= DW'(SCK_DIV / 2));
        i2s_ws  = (state == SHIFT) & (bitc >= 6'd31) & (bitc != 6'd63);
        i2s_sd  = state == LOAD ? mem[0][rp[0]][31] : (state == SHIFT) & sh[63];
    end
    always_ff @(posedge i_clk)
        for (int c = 0; c < 2; c++)
            if (push[c]) mem[c][wp[c]] <= apb.pwdata;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < 2; c++) begin
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
            en       <= 1'b0;
            stop_req <= 1'b0;
            sh       <= '0;
            bitc     <= '0;
            div      <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wp[c] <= nxt(wp[c]);
                if (pop)     rp[c] <= nxt(rp[c]);
                cnt[c] <= cnt[c] + CW'(push[c]) - CW'(pop);
            end
            // a 0 written mid-frame only requests a stop at the frame boundary
            if (wr & (a == 2'd0)) begin
                if (state == IDLE) en <= apb.pwdata[0];
                stop_req <= (state != IDLE) & ~apb.pwdata[0];
            end else if ((state == IDLE) & en & ~ready) begin
                en <= 1'b0;
            end else if ((state == SHIFT) & last & (state_nx == IDLE)) begin
                en       <= 1'b0;
                stop_req <= 1'b0;
            end
            if (state == LOAD) begin
                sh   <= {mem[0][rp[0]], mem[1][rp[1]]};
                bitc <= '0;
                div  <= DW'(1);
            end else if (state == SHIFT) begin
                if (div == DW'(SCK_DIV - 1)) begin
                    div  <= '0;
                    bitc <= bitc + 1'b1;
                    sh   <= {sh[62:0], 1'b0};
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_i2s.sv
// tb_apb_i2s: directed APB/I2S checks with hand-computed expectations
module tb_apb_i2s;
    timeunit 1ns;
    timeprecision 1ps;
    localparam int DIV = 4;
    logic i_clk = 0, i_rst = 1;
    logic sck, ws, sd;
    int checks = 0, errors = 0, edges = 0;
    bit  q_sd[$], q_ws[$];
    time q_t[$];
    apb_i2s_if bus();
    apb_i2s #(.FIFO_DEPTH(4), .SCK_DIV(DIV)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .apb(bus.slave),
        .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd)
    );
    always #5 i_clk = ~i_clk;
    always @(posedge sck) begin
        q_sd.push_back(sd);
        q_ws.push_back(ws);
        q_t.push_back($time);
        edges++;
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic apb(input logic w, input logic [31:0] addr, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        bus.paddr = addr; bus.pwdata = d; bus.pwrite = w; bus.psel = 1; bus.penable = 0;
        @(posedge i_clk); #1 bus.penable = 1;
        #3 r = bus.prdata; e = bus.pslverr;
        @(posedge i_clk); #1 bus.psel = 0; bus.penable = 0;
    endtask
    task automatic wr(input logic [31:0] addr, input logic [31:0] d, output logic e);
        logic [31:0] r;
        apb(1, addr, d, r, e);
    endtask
    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        apb(0, addr, 0, r, e);
        chk(tag, r, exp);
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask
    task automatic wait_edges(input string tag, input int n);
        int k = 0;
        while (edges < n && k < 5000) begin @(posedge i_clk); #1; k++; end
        chk(tag, edges >= n, 1);
    endtask
    task automatic chk_frame(input string tag, input int s, input logic [31:0] l, input logic [31:0] r);
        logic [31:0] gl = 0, gr = 0;
        int wbad = 0;
        if (q_sd.size() < s + 64) begin
            chk({tag, "_len"}, q_sd.size(), s + 64);
            return;
        end
        for (int i = 0; i < 32; i++) begin
            gl = {gl[30:0], q_sd[s + i]};
            gr = {gr[30:0], q_sd[s + 32 + i]};
        end
        for (int b = 0; b < 64; b++)
            if (q_ws[s + b] !== (b >= 31 && b < 63)) wbad++;
        chk({tag, "_l"}, gl, l);
        chk({tag, "_r"}, gr, r);
        chk({tag, "_ws"}, wbad, 0);
    endtask
    initial begin
        logic e, eacc;
        int base;
        time pmin, pmax, p;
        logic [31:0] lv [4] = '{32'h8000_0001, 32'h0F0F_F0F0, 32'hDEAD_BEEF, 32'h7FFF_FFFE};
        logic [31:0] rv [5] = '{32'h1111_2222, 32'hFFFF_0000, 32'h0000_0001, 32'hC001_D00D, 32'h5555_AAAA};
        bus.paddr = 0; bus.pwdata = 0; bus.pwrite = 0; bus.psel = 0; bus.penable = 0;
        repeat (3) @(posedge i_clk);
        #1 chk("rst_out", {sck, ws, sd, bus.pslverr}, 0);
        chk("rst_prdata", bus.prdata, 0);
        i_rst = 0;
        @(posedge i_clk); #1;
        rd_chk("sr_reset", 32'h04, 32'hA);
        rd_chk("cr_reset", 32'h00, 0);
        wr(32'h08, 32'hA5C3_0F81, e);
        chk("txr_err", e, 0);
        rd_chk("sr_txr", 32'h04, 32'h2);
        wr(32'h0C, 32'h1234_5678, e);
        rd_chk("sr_pair", 32'h04, 32'h0);
        rd_chk("rd_txr", 32'h08, 0);
        rd_chk("rd_txl", 32'h0C, 0);
        base = edges;
        wr(32'h00, 1, e);
        rd_chk("cr_run", 32'h00, 1);
        wait_edges("f1_wait", base + 64);
        idle(8);
        chk("f1_edges", edges - base, 64);
        chk_frame("f1", base, 32'h1234_5678, 32'hA5C3_0F81);
        rd_chk("cr_done", 32'h00, 0);
        rd_chk("sr_done", 32'h04, 32'hA);
        chk("sck_idle", sck, 0);
        for (int i = 0; i < 4; i++) begin
            wr(32'h0C, lv[i], e);
            wr(32'h08, rv[i], e);
        end
        rd_chk("sr_full", 32'h04, 32'h5);
        base = edges;
        wr(32'h00, 1, e);
        wait_edges("b4_wait", base + 256);
        idle(8);
        chk("b4_edges", edges - base, 256);
        for (int f = 0; f < 4; f++) chk_frame($sformatf("b4f%0d", f), base + 64 * f, lv[f], rv[f]);
        pmin = 64'hFFFF_FFFF; pmax = 0;
        for (int i = base + 1; i < base + 256 && i < q_t.size(); i++) begin
            p = q_t[i] - q_t[i - 1];
            if (p < pmin) pmin = p;
            if (p > pmax) pmax = p;
        end
        chk("b4_pmin", pmin, DIV * 10);
        chk("b4_pmax", pmax, DIV * 10);
        rd_chk("cr_b4", 32'h00, 0);
        chk("sck_b4", sck, 0);
        for (int i = 0; i < 2; i++) begin
            wr(32'h0C, lv[i], e);
            wr(32'h08, rv[i], e);
        end
        base = edges;
        wr(32'h00, 1, e);
        wr(32'h00, 0, e);
        rd_chk("cr_stopreq", 32'h00, 1);
        wait_edges("stop_wait", base + 64);
        idle(20);
        chk("stop_edges", edges - base, 64);
        rd_chk("cr_stopped", 32'h00, 0);
        rd_chk("sr_left1", 32'h04, 32'h0);
        wr(32'h00, 1, e);
        wait_edges("abort_wait", base + 80);
        i_rst = 1;
        @(posedge i_clk); #1;
        chk("abort_out", {sck, ws, sd}, 0);
        i_rst = 0;
        base = edges;
        idle(10);
        chk("abort_quiet", edges - base, 0);
        rd_chk("sr_abort", 32'h04, 32'hA);
        eacc = 0;
        for (int i = 0; i < 5; i++) begin
            wr(32'h08, rv[i], e);
            if (i < 4) eacc = eacc | e;
        end
        chk("ovf_ok4", eacc, 0);
        chk("ovf_err5", e, 1);
        rd_chk("sr_ovf", 32'h04, 32'h6);
        for (int i = 0; i < 4; i++) wr(32'h0C, lv[i], e);
        base = edges;
        wr(32'h00, 1, e);
        wait_edges("ovf_wait", base + 256);
        idle(8);
        for (int f = 0; f < 4; f++) chk_frame($sformatf("ovf%0d", f), base + 64 * f, lv[f], rv[f]);
        base = edges;
        wr(32'h00, 1, e);
        rd_chk("cr_empty", 32'h00, 0);
        idle(20);
        chk("empty_edges", edges - base, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
